ram_port_ctrl: RTL and testbench

RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

---
 rtl/ram_port_ctrl.sv | 117 +++++++++++
 tb/tb_ram_port_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_ctrl.sv
// Burst controller bridging a command/write-data stream onto a single-port RAM
// with a shared tri-state data bus; reads take two cycles per beat.
module ram_port_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [3:0]        cmd_len,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              rdata_last,
   output logic              cmd_done,
   output logic              ram_wr_en,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD_A = 2'd2,
      RD_D = 2'd3
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
         cmd_done    <= 1'b0;
      end else begin
         state       <= state_n;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
         cmd_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  addr_q <= cmd_addr;
                  cnt_q  <= cmd_len;
               end
            end
            WR: begin
               if (wdata_valid) begin
                  addr_q   <= addr_q + ADDR_W'(1);
                  cnt_q    <= cnt_q - 4'd1;
                  cmd_done <= (cnt_q == 4'd0);
               end
            end
            RD_D: begin
               // RAM drives the bus during RD_D; capture it on the closing edge
               rdata       <= ram_data;
               rdata_valid <= 1'b1;
               rdata_last  <= (cnt_q == 4'd0);
               cmd_done    <= (cnt_q == 4'd0);
               addr_q      <= addr_q + ADDR_W'(1);
               cnt_q       <= cnt_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n     = state;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      ram_wr_en   = 1'b0;
      ram_rd_en   = 1'b0;
      ram_addr    = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_n = cmd_write ? WR : RD_A;
         end
         WR: begin
            wdata_ready = 1'b1;
            ram_wr_en   = wdata_valid;
            ram_addr    = addr_q;
            if (wdata_valid && (cnt_q == 4'd0))
               state_n = IDLE;
         end
         RD_A: begin
            ram_rd_en = 1'b1;
            ram_addr  = addr_q;
            state_n   = RD_D;
         end
         RD_D: begin
            ram_rd_en = 1'b1;
            ram_addr  = addr_q;
            state_n   = (cnt_q != 4'd0) ? RD_A : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign ram_data = ram_wr_en ? wdata : 'z;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural two-cycle-read RAM on
// the shared bus; bus integrity is checked on every cycle.
module tb_ram_port_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [7:0]  cmd_addr;
   logic [3:0]  cmd_len;
   logic [31:0] wdata;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        rdata_last;
   logic        cmd_done;
   logic        ram_wr_en;
   logic        ram_rd_en;
   logic [7:0]  ram_addr;
   wire  [31:0] ram_data;

   ram_port_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
      .cmd_done(cmd_done), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
      .ram_addr(ram_addr), .ram_data(ram_data)
   );

   always #5 clk = ~clk;

   // RAM: captures the word on the first read edge, drives it the next cycle
   logic [31:0] mem [256];
   logic [31:0] ram_q;
   logic        ram_drive;
   assign ram_data = ram_drive ? ram_q : 'z;

   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr] <= ram_data;
      if (!reset_n) ram_drive <= 1'b0;
      else ram_drive <= ram_rd_en & ~ram_drive;
      if (ram_rd_en & ~ram_drive) ram_q <= mem[ram_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   int last_done_abs = -1;

   int          wr_cyc  [$];
   logic [7:0]  wr_addr [$];
   logic [31:0] wr_dat  [$];
   int          rd_cyc  [$];
   logic [31:0] rd_dat  [$];
   logic        rd_last [$];
   int          done_rel[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cmd_done) begin
         done_rel.push_back(cyc - acc_cyc);
         last_done_abs = cyc;
      end
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (ram_wr_en) begin
         wr_cyc.push_back(cyc - acc_cyc);
         wr_addr.push_back(ram_addr);
         wr_dat.push_back(ram_data);
         check("bus_wr", ram_data, wdata);
      end
      if (rdata_valid) begin
         rd_cyc.push_back(cyc - acc_cyc);
         rd_dat.push_back(rdata);
         rd_last.push_back(rdata_last);
      end
      if (ram_drive) check("bus_rd", ram_data, ram_q);
      check("excl", 32'(ram_wr_en & ram_rd_en), 32'd0);
   end

   task automatic clear_logs();
      wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
      rd_cyc.delete(); rd_dat.delete(); rd_last.delete(); done_rel.delete();
   endtask

   task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] len);
      bit ok = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      check("cmd_accept", 32'(ok), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic write_beats(input logic [31:0] base, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         bit ok = 0;
         if (gap > 0 && i > 0) begin
            wdata_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
         wdata_valid = 1'b1;
         wdata = base + 32'(i);
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wdata_ready) begin ok = 1; break; end
         end
         check("wr_ready", 32'(ok), 32'd1);
         @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
      wdata = 32'h5555_5555;
   endtask

   task automatic wait_done(input string tag);
      bit ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (cmd_done) begin ok = 1; break; end
      end
      check({tag, "_done_seen"}, 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_write(input string tag, input logic [7:0] a0, input int n,
                              input logic [31:0] base, input int gap);
      check({tag, "_nbeats"}, 32'(wr_cyc.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < wr_cyc.size()) begin
            check({tag, "_addr"}, 32'(wr_addr[i]), 32'(8'(a0 + 8'(i))));
            check({tag, "_data"}, wr_dat[i], base + 32'(i));
            check({tag, "_cyc"}, 32'(wr_cyc[i]), 32'(1 + i * (gap + 1)));
         end
      end
      check({tag, "_done"}, 32'((done_rel.size() > 0) ? done_rel[$] : -1),
            32'(2 + (n - 1) * (gap + 1)));
   endtask

   task automatic check_read(input string tag, input int n, input logic [31:0] base);
      check({tag, "_nbeats"}, 32'(rd_cyc.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < rd_cyc.size()) begin
            check({tag, "_cyc"}, 32'(rd_cyc[i]), 32'(3 + 2 * i));
            check({tag, "_data"}, rd_dat[i], base + 32'(i));
            check({tag, "_last"}, 32'(rd_last[i]), 32'(i == n - 1));
         end
      end
      check({tag, "_done"}, 32'((done_rel.size() > 0) ? done_rel[$] : -1), 32'(2 * n + 1));
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_len = '0; wdata = '0; wdata_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      check("rst_cmd_done", 32'(cmd_done), 32'd0);
      check("rst_wr_en", 32'(ram_wr_en), 32'd0);
      check("rst_rd_en", 32'(ram_rd_en), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // write data offered in IDLE must be ignored
      clear_logs();
      wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("idle_wdata_ready", 32'(wdata_ready), 32'd0);
      repeat (3) @(posedge clk); #1;
      wdata_valid = 1'b0;
      check("idle_no_write", 32'(wr_cyc.size()), 32'd0);

      // back-to-back write burst, then read it back
      clear_logs();
      send_cmd(1'b1, 8'h10, 4'd3);
      write_beats(32'hA0, 4, 0);
      wait_done("wr1");
      check_write("wr1", 8'h10, 4, 32'hA0, 0);

      clear_logs();
      send_cmd(1'b0, 8'h10, 4'd3);
      wait_done("rd1");
      check_read("rd1", 4, 32'hA0);

      // address wrap 0xFE -> 0xFF -> 0x00
      clear_logs();
      send_cmd(1'b1, 8'hFE, 4'd2);
      write_beats(32'hB0, 3, 0);
      wait_done("wrap_wr");
      check_write("wrap_wr", 8'hFE, 3, 32'hB0, 0);
      clear_logs();
      send_cmd(1'b0, 8'hFE, 4'd2);
      wait_done("wrap_rd");
      check_read("wrap_rd", 3, 32'hB0);

      // gapped write beats: 3 idle cycles between beats
      clear_logs();
      send_cmd(1'b1, 8'h40, 4'd1);
      write_beats(32'hC0, 2, 3);
      wait_done("gap_wr");
      check_write("gap_wr", 8'h40, 2, 32'hC0, 3);
      clear_logs();
      send_cmd(1'b0, 8'h40, 4'd1);
      wait_done("gap_rd");
      check_read("gap_rd", 2, 32'hC0);

      // new command accepted in the very cycle cmd_done pulses
      clear_logs();
      send_cmd(1'b1, 8'h60, 4'd0);
      write_beats(32'hD0, 1, 0);
      clear_logs();
      send_cmd(1'b0, 8'h60, 4'd0);
      check("b2b_accept_cyc", 32'(acc_cyc), 32'(last_done_abs));
      wait_done("b2b_rd");
      check_read("b2b_rd", 1, 32'hD0);

      // reset during RD_D of beat 2 of a 4-beat read
      clear_logs();
      send_cmd(1'b0, 8'h10, 4'd3);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rdata_valid", 32'(rdata_valid), 32'd0);
      check("mid_rdata_last", 32'(rdata_last), 32'd0);
      check("mid_cmd_done", 32'(cmd_done), 32'd0);
      check("mid_rdata", rdata, 32'd0);
      check("mid_rd_en", 32'(ram_rd_en), 32'd0);
      check("mid_wr_en", 32'(ram_wr_en), 32'd0);
      check("mid_ram_addr", 32'(ram_addr), 32'd0);
      check("mid_wdata_ready", 32'(wdata_ready), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("mid_release_ready", 32'(cmd_ready), 32'd1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("mid_rd_beats", 32'(rd_cyc.size()), 32'd1);
      check("mid_no_done", 32'(done_rel.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
